// File: rtl/pc_cache_switch_ctrl.sv
// pc_cache_switch_ctrl
// Watches the CPU program-counter tap for entry into the OS context-switch
// handler. On entry it stalls the CPU and runs a req/ack handshake with the
// cache bank-select logic. Software selects the target bank and reads status
// through a small Avalon-MM slave.
//
// Optional feature macro: PC_SWITCH_COUNT_EN
//   defined   -> 32-bit SW_COUNT at word address 3 counts completed switches;
//                any write to address 3 clears it.
//   undefined -> no counter is built; address 3 reads 0 and writes are ignored.

module pc_cache_switch_ctrl #(
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_BASE = 32'h0000_0100,
    parameter logic [PC_W-1:0] HANDLER_MASK = 32'hFFFF_FF00,
    parameter int unsigned     BANK_W       = 2,
    parameter int unsigned     TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              pc_valid,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              cache_switch_req,
    output logic [BANK_W-1:0] cache_switch_bank,
    input  logic              cache_switch_ack,
    output logic              cpu_stall,
    output logic              irq
);

    localparam int unsigned          CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        DONE      = 3'd2,
        ERR       = 3'd3,
        WAIT_EXIT = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Control register fields
    logic              ctrl_enable;
    logic              ctrl_irq_en;
    logic [BANK_W-1:0] ctrl_next_bank;

    // Status register fields
    logic              sts_busy;
    logic              sts_done;
    logic              sts_timeout;
    logic [BANK_W-1:0] current_bank;

    // Switch bookkeeping
    logic [PC_W-1:0]   last_pc;
    logic [BANK_W-1:0] latched_bank;
    logic [CNT_W-1:0]  to_cnt;
    logic              in_region;
    logic              prev_in_region;

    // One-cycle events decoded by the FSM
    logic              trigger;
    logic              switch_done;
    logic              switch_err;

    // Bus decode
    logic              ctrl_wr;
    logic              sts_wr;
    logic              cnt_wr;
    logic [31:0]       rd_mux;
    logic [31:0]       sw_count_rd;

    // Only a handful of write-data bits map onto register fields.
    logic              unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign in_region = ((pc_in & HANDLER_MASK) == HANDLER_BASE);

    assign ctrl_wr = avs_write && (avs_address == 2'd0);
    assign sts_wr  = avs_write && (avs_address == 2'd1);
    assign cnt_wr  = avs_write && (avs_address == 2'd3);

    assign cache_switch_bank = latched_bank;
    assign irq               = ctrl_irq_en & (sts_done | sts_timeout);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode and handshake outputs
    always_comb begin
        state_nxt        = state;
        cache_switch_req = 1'b0;
        cpu_stall        = 1'b0;
        sts_busy         = 1'b0;
        trigger          = 1'b0;
        switch_done      = 1'b0;
        switch_err       = 1'b0;
        case (state)
            IDLE: begin
                // Fire only on the edge into the handler region.
                if (ctrl_enable && pc_valid && in_region && !prev_in_region) begin
                    trigger   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cache_switch_req = 1'b1;
                cpu_stall        = 1'b1;
                sts_busy         = 1'b1;
                // Ack takes priority over an expiring counter in the same cycle.
                if (cache_switch_ack) begin
                    state_nxt = DONE;
                end else if (to_cnt == TIMEOUT_CNT) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                switch_done = 1'b1;
                state_nxt   = WAIT_EXIT;
            end
            ERR: begin
                switch_err = 1'b1;
                state_nxt  = WAIT_EXIT;
            end
            WAIT_EXIT: begin
                // Hold off retriggering until the CPU has left the handler.
                if (pc_valid && !in_region) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Region history, only advanced by valid PC samples
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_in_region <= 1'b0;
        end else if (pc_valid) begin
            prev_in_region <= in_region;
        end
    end

    // Handshake timeout counter: cleared on trigger, runs every REQ cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (trigger) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Capture PC and target bank at the trigger so they stay stable during REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc      <= '0;
            latched_bank <= '0;
        end else if (trigger) begin
            last_pc      <= pc_in;
            latched_bank <= ctrl_next_bank;
        end
    end

    // CTRL register
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable    <= 1'b0;
            ctrl_irq_en    <= 1'b0;
            ctrl_next_bank <= '0;
        end else if (ctrl_wr) begin
            ctrl_enable    <= avs_writedata[0];
            ctrl_irq_en    <= avs_writedata[1];
            ctrl_next_bank <= avs_writedata[8 +: BANK_W];
        end
    end

    // STATUS sticky flags and current bank; hardware set beats a W1C clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sts_done     <= 1'b0;
            sts_timeout  <= 1'b0;
            current_bank <= '0;
        end else begin
            if (switch_done) begin
                sts_done     <= 1'b1;
                current_bank <= latched_bank;
            end else if (sts_wr && avs_writedata[1]) begin
                sts_done <= 1'b0;
            end
            if (switch_err) begin
                sts_timeout <= 1'b1;
            end else if (sts_wr && avs_writedata[2]) begin
                sts_timeout <= 1'b0;
            end
        end
    end

`ifdef PC_SWITCH_COUNT_EN
    logic [31:0] sw_count;

    // Completed-switch counter; a write to its address clears it and wins
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_count <= '0;
        end else if (cnt_wr) begin
            sw_count <= '0;
        end else if (switch_done) begin
            sw_count <= sw_count + 32'd1;
        end
    end

    assign sw_count_rd = sw_count;
`else
    logic unused_cnt_wr;

    assign unused_cnt_wr = cnt_wr;
    assign sw_count_rd   = '0;
`endif

    // Read-data selection from the current register contents
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: begin
                rd_mux[0]            = ctrl_enable;
                rd_mux[1]            = ctrl_irq_en;
                rd_mux[8 +: BANK_W]  = ctrl_next_bank;
            end
            2'd1: begin
                rd_mux[0]            = sts_busy;
                rd_mux[1]            = sts_done;
                rd_mux[2]            = sts_timeout;
                rd_mux[8 +: BANK_W]  = current_bank;
            end
            2'd2: begin
                rd_mux = 32'(last_pc);
            end
            default: begin
                rd_mux = sw_count_rd;
            end
        endcase
    end

    // Registered read data, one cycle after the read strobe, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pc_cache_switch_ctrl.sv
// Directed self-checking bench for pc_cache_switch_ctrl.
// Inputs change 1 time unit after the rising edge and outputs are sampled there.

module tb_pc_cache_switch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        cache_switch_req;
    logic [1:0]  cache_switch_bank;
    logic        cache_switch_ack;
    logic        cpu_stall;
    logic        irq;

    int errors = 0;
    int checks = 0;

`ifdef PC_SWITCH_COUNT_EN
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    pc_cache_switch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .pc_in             (pc_in),
        .pc_valid          (pc_valid),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .cache_switch_req  (cache_switch_req),
        .cache_switch_bank (cache_switch_bank),
        .cache_switch_ack  (cache_switch_ack),
        .cpu_stall         (cpu_stall),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        step();
        data        = avs_readdata;
        avs_read    = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        seen_req;

        reset            = 1'b1;
        pc_in            = 32'h0;
        pc_valid         = 1'b0;
        avs_address      = 2'd0;
        avs_read         = 1'b0;
        avs_write        = 1'b0;
        avs_writedata    = 32'h0;
        cache_switch_ack = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_req",   cache_switch_req,  0);
        chk("rst_stall", cpu_stall,         0);
        chk("rst_irq",   irq,               0);
        chk("rst_bank",  cache_switch_bank, 0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("rst_reg%0d", a), d, 0);
        end

        // First switch: enable, irq_en, bank 2; ack after a few cycles
        wr(2'd0, 32'h0000_0203);
        pc_in    = 32'h0000_0104;
        pc_valid = 1'b1;
        step();
        chk("t2_req",   cache_switch_req,  1);
        chk("t2_bank",  cache_switch_bank, 2);
        chk("t2_stall", cpu_stall,         1);
        repeat (4) step();
        chk("t2_req_held", cache_switch_req, 1);
        cache_switch_ack = 1'b1;
        step();
        cache_switch_ack = 1'b0;
        chk("t2_req_drop",   cache_switch_req, 0);
        chk("t2_stall_drop", cpu_stall,        0);
        step();
        chk("t2_irq", irq, 1);
        cache_switch_ack = 1'b1;
        step();
        cache_switch_ack = 1'b0;
        chk("t2_stray_ack", cache_switch_req, 0);
        rd(2'd1, d);
        chk("t2_status", d, 32'h0000_0202);
        rd(2'd2, d);
        chk("t2_last_pc", d, 32'h0000_0104);
        rd(2'd0, d);
        chk("t2_ctrl", d, 32'h0000_0203);

        // Staying inside the handler must not retrigger
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc_in = 32'h0000_0100 + 32'(4 * ((i * 7) % 64));
            step();
            if (cache_switch_req) seen_req = 1'b1;
        end
        chk("t3_no_retrigger", seen_req, 0);
        pc_in = 32'h0000_0200;
        step();
        pc_in = 32'h0000_0108;
        step();
        chk("t3_second_req", cache_switch_req, 1);
        cache_switch_ack = 1'b1;
        step();
        cache_switch_ack = 1'b0;
        // W1C of done in the very cycle hardware sets it: set wins
        wr(2'd1, 32'h0000_0002);
        rd(2'd1, d);
        chk("t3_set_beats_w1c", d, 32'h0000_0202);
        wr(2'd1, 32'h0000_0002);
        chk("t3_irq_cleared", irq, 0);

        // Timeout: bank 1 requested, never acked
        wr(2'd0, 32'h0000_0103);
        pc_in = 32'h0000_0300;
        step();
        pc_in = 32'h0000_0110;
        step();
        chk("t4_req",  cache_switch_req,  1);
        chk("t4_bank", cache_switch_bank, 1);
        wr(2'd0, 32'h0000_0303);
        chk("t4_bank_stable", cache_switch_bank, 1);
        pc_valid = 1'b0;
        repeat (254) step();
        chk("t4_req_last_cycle", cache_switch_req, 1);
        step();
        chk("t4_req_drop",   cache_switch_req, 0);
        chk("t4_stall_drop", cpu_stall,        0);
        step();
        chk("t4_irq", irq, 1);
        rd(2'd1, d);
        chk("t4_status", d, 32'h0000_0204);
        wr(2'd1, 32'h0000_0004);
        chk("t4_irq_clr", irq, 0);
        rd(2'd1, d);
        chk("t4_status_clr", d, 32'h0000_0200);

        // Ack arriving in the exact timeout cycle completes normally
        pc_valid = 1'b1;
        pc_in    = 32'h0000_0300;
        step();
        pc_in = 32'h0000_0120;
        step();
        chk("t5_bank", cache_switch_bank, 3);
        repeat (255) step();
        chk("t5_req_last_cycle", cache_switch_req, 1);
        cache_switch_ack = 1'b1;
        step();
        cache_switch_ack = 1'b0;
        chk("t5_req_drop", cache_switch_req, 0);
        step();
        rd(2'd1, d);
        chk("t5_status", d, 32'h0000_0302);
        rd(2'd2, d);
        chk("t5_last_pc", d, 32'h0000_0120);
        rd(2'd3, d);
        chk("t6_sw_count", d, EXP_CNT3);
        wr(2'd3, 32'h0);
        rd(2'd3, d);
        chk("t6_sw_count_clr", d, 0);

        // Reset in the middle of a request
        pc_in = 32'h0000_0300;
        step();
        pc_in = 32'h0000_0130;
        step();
        chk("t5_rst_req_on", cache_switch_req, 1);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("t5_rst_req",   cache_switch_req, 0);
        chk("t5_rst_stall", cpu_stall,        0);
        chk("t5_rst_irq",   irq,              0);
        reset    = 1'b0;
        pc_valid = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("t5_rst_reg%0d", a), d, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
